load_scheduler: RTL
===================

Name: load_scheduler

Overview:
- Sequences the IFM and weight preload phase ahead of the PE array compute.
- Shares one external memory read channel between two load streams: IFM and weights.
- Issues word-address read requests in round-robin bursts and tracks outstanding requests with a tag FIFO.
- Routes in-order responses to the IFM buffer or weight buffer write port, then signals done to the top-level control FSM so it can move to the compute phase.

Parameters:
- ADDR_W, 32, memory word-address width
- DATA_W, 32, data word width
- CNT_W, 16, word-count and buffer-address width
- BURST_LEN, 16, maximum consecutive requests granted to one stream
- MAX_OUTST, 4, maximum outstanding read requests; tag FIFO depth (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin load; sampled only in IDLE
- ifm_base_addr  in  ADDR_W  IFM word base address
- ifm_words  in  CNT_W  IFM words to load
- wgt_base_addr  in  ADDR_W  weight word base address
- wgt_words  in  CNT_W  weight words to load
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  read request accepted
- mem_req_addr  out  ADDR_W  read word address
- mem_rsp_valid  in  1  response valid; in-order, no backpressure
- mem_rsp_data  in  DATA_W  response data
- ifm_wr_en  out  1  IFM buffer write strobe
- ifm_wr_addr  out  CNT_W  IFM buffer word address
- ifm_wr_data  out  DATA_W  IFM buffer write data
- wgt_wr_en  out  1  weight buffer write strobe
- wgt_wr_addr  out  CNT_W  weight buffer word address
- wgt_wr_data  out  DATA_W  weight buffer write data
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- rsp_err  out  1  sticky flag: response arrived with nothing outstanding

Behaviour:
- Reset:
  - All outputs 0.
  - FSM goes to IDLE; counters, tag FIFO and grant pointer are cleared.
  - Reset mid-load discards every outstanding request. Responses arriving after reset are handled by the rsp_err rule.
- States: IDLE, ARB, BURST, DRAIN, DONE.
- IDLE:
  - On start, latch all config inputs, clear rsp_err, zero the issue and write counters, set the grant pointer to IFM, go to ARB.
  - start in any other state is ignored.
- ARB:
  - Pick the stream with remaining unissued words.
  - If both have words left, pick the stream the grant pointer selects, then toggle the pointer.
  - Load burst_cnt = min(BURST_LEN, remaining) and go to BURST.
  - If neither stream has unissued words, go to DRAIN. A start with ifm_words = wgt_words = 0 passes through ARB and DRAIN to DONE.
- BURST:
  - Raise mem_req_valid only when outstanding < MAX_OUTST.
  - Once raised, mem_req_valid and mem_req_addr hold stable until mem_req_ready.
  - mem_req_addr = latched base of the granted stream + that stream's issue counter.
  - On accept (valid && ready): push the stream tag (0 = IFM, 1 = wgt) into the tag FIFO, increment the issue counter, decrement burst_cnt.
  - When burst_cnt reaches 0, go to ARB. mem_req_valid drops in the cycle after the last accept.
- Responses (any non-IDLE state):
  - On mem_rsp_valid, pop a tag.
  - Next cycle, assert exactly one of ifm_wr_en / wgt_wr_en, with data = mem_rsp_data and addr = that stream's write counter; then increment the counter. Latency is 1 cycle.
- Outstanding count:
  - Push only: +1. Pop only: -1. Simultaneous push and pop: unchanged.
  - At outstanding == MAX_OUTST no new request is raised; an accept and a response in the same cycle are legal.
- Error case: mem_rsp_valid with outstanding == 0 means no pop and no write; set rsp_err, which holds until the next accepted start.
- DRAIN: wait until outstanding == 0 and the last buffer write has been issued, then go to DONE.
- DONE: pulse done for one cycle, drop busy in that same cycle, return to IDLE.
- Width rule: counters are CNT_W bits with no wrap. Up to 2^CNT_W-1 words per stream is supported, and address addition truncates to ADDR_W.

Test Plan:
- ifm_words=40, wgt_words=8, BURST_LEN=16, ready always 1, 2-cycle response latency:
  - request order is IFM 0-15, wgt 0-7, IFM 16-31, IFM 32-39;
  - 40 ifm_wr_en and 8 wgt_wr_en occur with sequential addresses;
  - done is a single pulse.
- Responses withheld after 4 accepts:
  - mem_req_valid stays 0 with outstanding=4;
  - issuing resumes on the cycle after the first response.
- mem_req_ready low for 5 cycles mid-burst:
  - mem_req_valid and mem_req_addr stay stable with no duplicate request;
  - address sequence is gap-free.
- start with ifm_words=0, wgt_words=0:
  - no mem_req_valid;
  - done pulses within 4 cycles.
- Spurious mem_rsp_valid while in IDLE:
  - rsp_err=1 and no buffer write;
  - next start clears rsp_err.
- rst asserted mid-BURST with 3 outstanding:
  - next cycle all outputs are 0 and state is IDLE;
  - a fresh start with ifm_words=4 then loads IFM addresses 0-3 correctly.

Source files
------------

// File: rtl/load_scheduler.sv
// Preload sequencer: shares one memory read channel between the IFM and weight
// streams in round-robin bursts, tracks in-flight reads with a tag FIFO, routes responses.
module load_scheduler #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int BURST_LEN = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] ifm_base_addr,
  input  logic [CNT_W-1:0]  ifm_words,
  input  logic [ADDR_W-1:0] wgt_base_addr,
  input  logic [CNT_W-1:0]  wgt_words,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              ifm_wr_en,
  output logic [CNT_W-1:0]  ifm_wr_addr,
  output logic [DATA_W-1:0] ifm_wr_data,
  output logic              wgt_wr_en,
  output logic [CNT_W-1:0]  wgt_wr_addr,
  output logic [DATA_W-1:0] wgt_wr_data,
  output logic              busy,
  output logic              done,
  output logic              rsp_err
);

  // state | meaning
  // IDLE  | waiting for start
  // ARB   | choose next stream and burst length
  // BURST | issuing reads for the granted stream
  // DRAIN | all reads issued, waiting for responses
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, ARB, BURST, DRAIN, DONE} state_t;

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OST_W = PTR_W + 1;
  localparam logic [OST_W-1:0] OST_MAX   = OST_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ifm_base, wgt_base;
  logic [CNT_W-1:0]  ifm_total, wgt_total;
  logic [CNT_W-1:0]  ifm_iss, wgt_iss;
  logic [CNT_W-1:0]  ifm_wcnt, wgt_wcnt;
  logic [CNT_W-1:0]  burst_cnt;
  logic              grant_ptr, cur_sel;
  logic              tag_mem [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OST_W-1:0]  outst;

  logic [CNT_W-1:0]  ifm_rem, wgt_rem, arb_rem, arb_len;
  logic              ifm_left, wgt_left, arb_sel;
  logic              accept, pop, rsp_tag;

  assign ifm_rem  = ifm_total - ifm_iss;
  assign wgt_rem  = wgt_total - wgt_iss;
  assign ifm_left = (ifm_rem != '0);
  assign wgt_left = (wgt_rem != '0);
  assign arb_sel  = (ifm_left && wgt_left) ? grant_ptr : !ifm_left;
  assign arb_rem  = arb_sel ? wgt_rem : ifm_rem;
  assign arb_len  = (arb_rem > BURST_MAX) ? BURST_MAX : arb_rem;

  // valid depends only on registered state, so it cannot drop before ready
  assign mem_req_valid = (state == BURST) && (outst < OST_MAX);
  assign mem_req_addr  = !mem_req_valid ? '0 :
                         cur_sel ? wgt_base + ADDR_W'(wgt_iss) : ifm_base + ADDR_W'(ifm_iss);
  assign accept  = mem_req_valid && mem_req_ready;
  assign pop     = mem_rsp_valid && (outst != '0);
  assign rsp_tag = tag_mem[rd_ptr];
  assign busy    = (state == ARB) || (state == BURST) || (state == DRAIN);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARB;
      ARB:     state_nxt = (ifm_left || wgt_left) ? BURST : DRAIN;
      BURST:   if (accept && burst_cnt == CNT_W'(1)) state_nxt = ARB;
      // the final write strobe is registered on the same edge outst reaches 0
      DRAIN:   if (outst == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifm_base    <= '0;
      wgt_base    <= '0;
      ifm_total   <= '0;
      wgt_total   <= '0;
      ifm_iss     <= '0;
      wgt_iss     <= '0;
      ifm_wcnt    <= '0;
      wgt_wcnt    <= '0;
      burst_cnt   <= '0;
      grant_ptr   <= 1'b0;
      cur_sel     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outst       <= '0;
      ifm_wr_en   <= 1'b0;
      ifm_wr_addr <= '0;
      ifm_wr_data <= '0;
      wgt_wr_en   <= 1'b0;
      wgt_wr_addr <= '0;
      wgt_wr_data <= '0;
      rsp_err     <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) tag_mem[i] <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        ifm_base  <= ifm_base_addr;
        wgt_base  <= wgt_base_addr;
        ifm_total <= ifm_words;
        wgt_total <= wgt_words;
        ifm_iss   <= '0;
        wgt_iss   <= '0;
        ifm_wcnt  <= '0;
        wgt_wcnt  <= '0;
        grant_ptr <= 1'b0;
        rsp_err   <= 1'b0;
      end

      if (state == ARB) begin
        cur_sel   <= arb_sel;
        burst_cnt <= arb_len;
        if (ifm_left && wgt_left) grant_ptr <= ~grant_ptr;
      end

      if (accept) begin
        tag_mem[wr_ptr] <= cur_sel;
        wr_ptr          <= wr_ptr + PTR_W'(1);
        burst_cnt       <= burst_cnt - CNT_W'(1);
        if (cur_sel) wgt_iss <= wgt_iss + CNT_W'(1);
        else         ifm_iss <= ifm_iss + CNT_W'(1);
      end

      ifm_wr_en <= pop && !rsp_tag;
      wgt_wr_en <= pop && rsp_tag;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (rsp_tag) begin
          wgt_wr_addr <= wgt_wcnt;
          wgt_wr_data <= mem_rsp_data;
          wgt_wcnt    <= wgt_wcnt + CNT_W'(1);
        end else begin
          ifm_wr_addr <= ifm_wcnt;
          ifm_wr_data <= mem_rsp_data;
          ifm_wcnt    <= ifm_wcnt + CNT_W'(1);
        end
      end

      case ({accept, pop})
        2'b10:   outst <= outst + OST_W'(1);
        2'b01:   outst <= outst - OST_W'(1);
        default: outst <= outst;
      endcase

      if (mem_rsp_valid && outst == '0) rsp_err <= 1'b1;
    end
  end

endmodule
